// File: rtl/fx2fp16_converter.sv
// rtl/fx2fp16_converter.sv - signed fixed-point to IEEE-754 binary16 converter, bit-serial normalisation
module fx2fp16_converter #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Exponent of a magnitude whose MSB already sits at bit 15 (no shifts).
    localparam logic [5:0] EXP_TOP = 6'(30 - FRAC_BITS);

    state_t      state;
    logic [15:0] mag;
    logic        sgn;
    logic [3:0]  shift_cnt;

    logic [9:0]  mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [10:0] mant_sum;
    logic [5:0]  exp_base;
    logic [5:0]  exp_final;
    logic [15:0] result;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Round-to-nearest-even packing of the normalised magnitude; the hidden one is mag[15].
    always_comb begin
        mant      = mag[14:5];
        guard     = mag[4];
        sticky    = |mag[3:0];
        round_up  = guard & (sticky | mant[0]);
        mant_sum  = {1'b0, mant} + {10'd0, round_up};
        exp_base  = EXP_TOP - {2'b00, shift_cnt};
        exp_final = exp_base + {5'd0, mant_sum[10]};
        result    = 16'h0000;
        if (mag != 16'h0000) begin
            // A carry out of the mantissa means 1.111..1 rounded up to 10.000..0.
            result = {sgn, exp_final[4:0], (mant_sum[10] ? 10'd0 : mant_sum[9:0])};
        end
    end

    // Control FSM: accept, shift one bit per cycle until normalised, round, hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            mag       <= '0;
            sgn       <= 1'b0;
            shift_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn       <= in_data[15];
                        // Negating 0x8000 wraps back to 0x8000, which is the correct magnitude.
                        mag       <= in_data[15] ? (~in_data + 16'd1) : in_data;
                        shift_cnt <= '0;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if ((mag == 16'h0000) || mag[15]) begin
                        state <= ROUND;
                    end else begin
                        mag       <= {mag[14:0], 1'b0};
                        shift_cnt <= shift_cnt + 4'd1;
                    end
                end
                ROUND: begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fx2fp16_converter.md
FX2FP16_CONVERTER -- requirements
Module: fx2fp16_converter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, output width; only the value 16 is supported.
REQ-002 SHALL have parameter FRAC_BITS, default 8, number of fractional bits in the input; legal range 0..14.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_data holds a valid operand.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_data  input  16  signed two's-complement fixed-point operand with FRAC_BITS fractional bits.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  IEEE-754 binary16 result: sign[15], exponent[14:10] with bias 15, mantissa[9:0].
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; an operand is accepted on an edge where state=IDLE and in_valid=1.
REQ-014 SHALL, on acceptance, register the sign as in_data[15] and the 16-bit unsigned magnitude |in_data|, with 0x8000 giving magnitude 0x8000, clear the shift count, and go to NORM.
REQ-015 SHALL, in NORM on each edge: if magnitude==0 or magnitude[15]==1, go to ROUND; otherwise shift the magnitude left by 1 and increment the shift count (one bit per cycle, no multi-bit shifter).
REQ-016 SHALL, in ROUND, compute: mantissa=mag[14:5], guard=mag[4], sticky=OR(mag[3:0]), exponent=30-FRAC_BITS-shift_count.
REQ-017 SHALL round to nearest, ties to even: increment the mantissa when guard & (sticky | mantissa[0]).
REQ-018 SHALL, on mantissa carry-out, set the mantissa to 0 and increment the exponent by 1; with FRAC_BITS in range, the exponent never reaches 31 and no subnormal is produced.
REQ-019 SHALL produce out_data=0x0000 for a zero magnitude, always positive zero.
REQ-020 SHALL register out_data on the ROUND->DONE edge and raise out_valid in DONE.
REQ-021 SHALL hold out_data and out_valid stable in DONE until an edge with out_ready=1, then go to IDLE with out_valid=0.
REQ-022 SHALL ignore out_ready outside DONE, and ignore in_valid and in_data outside IDLE.
REQ-023 SHALL have latency, counted in edges from the accept edge to the edge that raises out_valid, of 2+(15-p), where p is the bit index of the magnitude MSB; zero input gives 2, minimum is 2, maximum is 17.
REQ-024 SHALL give a throughput of one operand per latency+1 cycles when out_ready is held at 1; operand pipelining is not supported.
REQ-025 SHALL keep out_data unchanged outside DONE, holding the last result.

Reset
REQ-026 SHALL, on an edge with rst=1, set state=IDLE, out_valid=0, out_data=0x0000, and clear magnitude, sign and shift count.
REQ-027 SHALL give rst priority over every handshake; a reset in NORM, ROUND or DONE discards the operation and emits no result.
REQ-028 SHALL drive in_ready=1 and busy=0 in the first cycle after reset is released.

Verification
REQ-029 SHALL cover basic conversion with FRAC_BITS=8, out_ready=1: in_data 0x0100 -> 0x3C00 after 9 edges; 0xFF00 -> 0xBC00; 0x0000 -> 0x0000 after 2 edges.
REQ-030 SHALL cover the extremes: 0x8000 -> 0xD800 after 2 edges; 0x0001 -> 0x1C00 after 17 edges; 0x7FFF -> 0x5800, where the rounding carry bumps the exponent.
REQ-031 SHALL cover tie rounding: 0x0801 -> 0x4800, tie with even LSB so no increment; 0x0803 -> 0x4802, tie with odd LSB so increment.
REQ-032 SHALL cover output backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay constant and in_ready stays 0; release out_ready -> IDLE on the next edge.
REQ-033 SHALL cover reset mid-operation: assert rst in NORM during a 0x0001 conversion -> next cycle out_valid=0, in_ready=1, out_data=0x0000; a fresh 0x0100 then yields 0x3C00.
REQ-034 SHALL cover back-to-back operands: keep in_valid=1 with in_data changing every cycle -> only the value present on each IDLE edge is accepted; every other value is ignored.
